stopwatch_ctrl: RTL and testbench

//  Sequencer for the hh:mm:ss timer counter. Debounces two push-buttons and

---
 rtl/stopwatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button debounce, start/pause/lap/reset FSM,
// one-second run tick, timer clear pulse and live/lap display mux.

module stopwatch_ctrl_deb #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Count only while the synced level disagrees with the debounced one;
    // a bounce back to the debounced level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 != r_deb) begin
                if (r_cnt == C_LAST) begin
                    r_deb   <= r_s2;
                    r_cnt   <= '0;
                    r_press <= r_s2;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;
endmodule

module stopwatch_ctrl #(
    parameter int DIV     = 100_000_000,
    parameter int DEB_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [5:0] t_sec,
    input  logic [5:0] t_min,
    input  logic [4:0] t_hr,
    output logic       run,
    output logic       tclr,
    output logic [1:0] state,
    output logic [5:0] d_sec,
    output logic [5:0] d_min,
    output logic [4:0] d_hr
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic          w_ss;
    logic          w_lr;
    logic          w_tclr;
    logic          w_cap;
    logic          w_cnt_en;
    logic          r_run;
    logic          r_tclr;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_lap_sec;
    logic [5:0]    r_lap_min;
    logic [4:0]    r_lap_hr;

    stopwatch_ctrl_deb #(.DEB_CYC(DEB_CYC)) u_deb_ss (
        .clk     (clk),
        .rst     (clr),
        .i_btn   (btn_ss),
        .o_press (w_ss)
    );

    stopwatch_ctrl_deb #(.DEB_CYC(DEB_CYC)) u_deb_lr (
        .clk     (clk),
        .rst     (clr),
        .i_btn   (btn_lr),
        .o_press (w_lr)
    );

    always_comb begin
        w_nxt  = r_state;
        w_tclr = 1'b0;
        w_cap  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ss)      w_nxt  = S_RUN;
                else if (w_lr) w_tclr = 1'b1;
            end
            S_RUN: begin
                if (w_ss) begin
                    w_nxt = S_PAUSE;
                end else if (w_lr) begin
                    w_nxt = S_LAP;
                    w_cap = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss)      w_nxt = S_PAUSE;
                else if (w_lr) w_nxt = S_RUN;
            end
            S_PAUSE: begin
                if (w_ss) begin
                    w_nxt = S_RUN;
                end else if (w_lr) begin
                    w_nxt  = S_IDLE;
                    w_tclr = 1'b1;
                end
            end
        endcase
    end

    // Counting stops on the pausing edge itself so no tick lands in PAUSED.
    assign w_cnt_en = (r_state == S_RUN || r_state == S_LAP) &&
                      (w_nxt == S_RUN || w_nxt == S_LAP);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_tclr    <= 1'b0;
            r_presc   <= '0;
            r_lap_sec <= '0;
            r_lap_min <= '0;
            r_lap_hr  <= '0;
        end else begin
            r_state <= w_nxt;
            r_tclr  <= w_tclr;
            r_run   <= 1'b0;
            if (w_nxt == S_IDLE || w_tclr) begin
                r_presc <= '0;
            end else if (w_cnt_en) begin
                if (r_presc == P_LAST) begin
                    r_presc <= '0;
                    r_run   <= 1'b1;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
            if (w_cap) begin
                r_lap_sec <= t_sec;
                r_lap_min <= t_min;
                r_lap_hr  <= t_hr;
            end
        end
    end

    assign run   = r_run;
    assign tclr  = r_tclr;
    assign state = r_state;
    assign d_sec = (r_state == S_LAP) ? r_lap_sec : t_sec;
    assign d_min = (r_state == S_LAP) ? r_lap_min : t_min;
    assign d_hr  = (r_state == S_LAP) ? r_lap_hr  : t_hr;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: window-based debounce model,
// event-level FSM and elapsed-cycle tick model, per-cycle output compare.

module tb_stopwatch_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 3;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int LAP   = 2;
    localparam int PAUSE = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_ss;
    logic       btn_lr;
    logic [5:0] t_sec;
    logic [5:0] t_min;
    logic [4:0] t_hr;
    logic       run;
    logic       tclr;
    logic [1:0] state;
    logic [5:0] d_sec;
    logic [5:0] d_min;
    logic [4:0] d_hr;

    stopwatch_ctrl #(.DIV(DIV), .DEB_CYC(DEB)) dut (
        .clk    (clk),
        .clr    (clr),
        .btn_ss (btn_ss),
        .btn_lr (btn_lr),
        .t_sec  (t_sec),
        .t_min  (t_min),
        .t_hr   (t_hr),
        .run    (run),
        .tclr   (tclr),
        .state  (state),
        .d_sec  (d_sec),
        .d_min  (d_min),
        .d_hr   (d_hr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       run;
        logic       tclr;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;

    // reference model state
    bit [DEB+1:0] m_hist [2];
    bit           m_deb  [2];
    bit           m_pr   [2];
    int           m_st;
    bit           m_run;
    bit           m_tclr;
    int unsigned  m_elapsed;
    logic [5:0]   m_ls;
    logic [5:0]   m_lm;
    logic [4:0]   m_lh;

    function automatic bit counting(input int s);
        return (s == RUN) || (s == LAP);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = '0;
            m_deb[b]  = 1'b0;
            m_pr[b]   = 1'b0;
        end
        m_st      = IDLE;
        m_run     = 1'b0;
        m_tclr    = 1'b0;
        m_elapsed = 0;
        m_ls      = '0;
        m_lm      = '0;
        m_lh      = '0;
    endtask

    // One clock edge, using the input values present before the edge.
    task automatic model_edge();
        bit ss, lr, all1, all0;
        bit raw [2];
        int nst;
        ss     = m_pr[0];
        lr     = m_pr[1];
        raw[0] = btn_ss;
        raw[1] = btn_lr;
        nst    = m_st;
        m_tclr = 1'b0;
        if (ss) begin
            nst = counting(m_st) ? PAUSE : RUN;
        end else if (lr) begin
            case (m_st)
                IDLE:  m_tclr = 1'b1;
                RUN: begin
                    nst  = LAP;
                    m_ls = t_sec;
                    m_lm = t_min;
                    m_lh = t_hr;
                end
                LAP:   nst = RUN;
                default: begin
                    nst    = IDLE;
                    m_tclr = 1'b1;
                end
            endcase
        end
        m_run = 1'b0;
        if (nst == IDLE) begin
            m_elapsed = 0;
        end else if (counting(m_st) && counting(nst)) begin
            m_elapsed++;
            m_run = (m_elapsed % DIV) == 0;
        end
        m_st = nst;
        // debounced level follows once the last DEB synced samples
        // (raw sampled two edges earlier and before) all disagree with it
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][DEB:0], raw[b]};
            all1 = &m_hist[b][DEB+1:2];
            all0 = ~|m_hist[b][DEB+1:2];
            m_pr[b] = !m_deb[b] && all1;
            if (m_deb[b] ? all0 : all1) m_deb[b] = !m_deb[b];
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.st   = 2'(m_st);
        e.run  = m_run;
        e.tclr = m_tclr;
        e.s    = (m_st == LAP) ? m_ls : t_sec;
        e.m    = (m_st == LAP) ? m_lm : t_min;
        e.h    = (m_st == LAP) ? m_lh : t_hr;
        return e;
    endfunction

    task automatic cycle(input logic ss, input logic lr, input logic c);
        @(posedge clk);
        if (!clr) model_edge();
        #1;
        btn_ss = ss;
        btn_lr = lr;
        clr    = c;
        t_sec  = 6'($urandom_range(59));
        t_min  = 6'($urandom_range(59));
        t_hr   = 5'($urandom_range(23));
        if (c) model_reset();
        q.push_back(expect_now());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic ss, input logic lr, input int n);
        repeat (n) cycle(ss, lr, 1'b0);
        idle(10);
    endtask

    // monitor: one scoreboard entry per DUT cycle
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                g = {state, run, tclr, d_sec, d_min, d_hr};
                checks++;
                ncyc++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cyc%0d outputs: got st=%0d run=%0b tclr=%0b d=%0d:%0d:%0d want st=%0d run=%0b tclr=%0b d=%0d:%0d:%0d",
                             ncyc, g.st, g.run, g.tclr, g.h, g.m, g.s,
                             e.st, e.run, e.tclr, e.h, e.m, e.s);
                end
            end
        end
    end

    initial begin
        int r, n;
        logic ss, lr;
        clr    = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        t_sec  = 6'd0;
        t_min  = 6'd0;
        t_hr   = 5'd0;
        model_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        idle(50);
        // start, held 10 cycles
        press(1'b1, 1'b0, 10);
        idle(9);
        // bouncing stop press then resume
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 6);
        // lap freeze and release
        press(1'b0, 1'b1, 6);
        idle(15);
        press(1'b0, 1'b1, 6);
        // pause, resume, pause, clear
        press(1'b1, 1'b0, 5);
        idle(7);
        press(1'b1, 1'b0, 5);
        idle(3);
        press(1'b1, 1'b0, 5);
        press(1'b0, 1'b1, 5);
        // clear from IDLE
        press(1'b0, 1'b1, 5);
        // simultaneous presses from RUNNING, then clr during LAP
        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b1, 5);
        press(1'b1, 1'b0, 5);
        press(1'b0, 1'b1, 5);
        idle(3);
        cycle(1'b0, 1'b0, 1'b1);
        idle(20);
        // randomized phase with bounces and occasional clr
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(11);
            if (r == 0) begin
                cycle(1'b0, 1'b0, 1'b1);
                if ($urandom_range(1) == 1) cycle(1'b0, 1'b0, 1'b1);
            end else begin
                ss = (r <= 6);
                lr = (r >= 5);
                n  = $urandom_range(8, 1);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(4) == 0)
                        cycle(~ss, lr, 1'b0);
                    else
                        cycle(ss, lr, 1'b0);
                end
            end
            idle($urandom_range(9, 1));
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
